// File: rtl/soc_us_timer_if.sv
// CPU bus bundle for the microsecond timer.
//   bus_req   : access request, one-cycle pulse (CPU -> timer)
//   bus_we    : 1 = write, 0 = read, qualified by bus_req
//   bus_addr  : word index 0=CNT 1=CMP 2=CTRL 3=STAT
//   bus_wdata : write data
//   bus_rdata : read data, valid with bus_ack (timer -> CPU)
//   bus_ack   : one-cycle acknowledge, one clock after bus_req
interface soc_us_timer_if;
  logic        bus_req;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/soc_us_timer.sv
// Microsecond system timer: free-running up-counter advanced by tick_1us,
// compare match with one-shot / periodic modes and a level interrupt.
// Ports:
//   clk_54   : system clock
//   srst54   : synchronous active-high reset
//   tick_1us : one-cycle pulse every microsecond
//   bus      : CPU register bus (slave side), 1-cycle registered ack/rdata
//   irq      : level interrupt, STAT.MATCH & CTRL.IRQ_EN
module soc_us_timer #(
  parameter int CNT_W = 32
) (
  input  logic               clk_54,
  input  logic               srst54,
  input  logic               tick_1us,
  soc_us_timer_if.slave      bus,
  output logic               irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cmp_reg, cmp_next;
  logic             en_reg, en_next;
  logic             per_reg, per_next;
  logic             irq_en_reg, irq_en_next;
  logic             match_reg, match_next;
  logic [31:0]      rdata_reg, rdata_next;
  logic             ack_reg;

  logic [31:0]      rd_val;
  logic             wr_cnt, wr_cmp, wr_ctrl, wr_stat;
  logic             tick_ev, hit;

  // Register read mux; values are sampled before this edge's update.
  always_comb begin
    rd_val = '0;
    case (bus.bus_addr)
      2'd0:    rd_val[CNT_W-1:0] = cnt_reg;
      2'd1:    rd_val[CNT_W-1:0] = cmp_reg;
      2'd2:    rd_val[2:0]       = {irq_en_reg, per_reg, en_reg};
      default: rd_val[0]         = match_reg;
    endcase
  end

  always_comb begin
    wr_cnt  = bus.bus_req && bus.bus_we && (bus.bus_addr == 2'd0);
    wr_cmp  = bus.bus_req && bus.bus_we && (bus.bus_addr == 2'd1);
    wr_ctrl = bus.bus_req && bus.bus_we && (bus.bus_addr == 2'd2);
    wr_stat = bus.bus_req && bus.bus_we && (bus.bus_addr == 2'd3);
    tick_ev = en_reg && tick_1us;
    // Compare uses the current CMP, so a same-edge CMP write only
    // takes effect from the following tick.
    hit     = tick_ev && (cnt_reg == cmp_reg);
  end

  always_comb begin
    // A CPU write to CNT overrides (and swallows) a coincident tick.
    cnt_next = cnt_reg;
    if (wr_cnt)
      cnt_next = bus.bus_wdata[CNT_W-1:0];
    else if (tick_ev)
      cnt_next = (hit && per_reg) ? '0 : cnt_reg + CNT_ONE;

    cmp_next = wr_cmp ? bus.bus_wdata[CNT_W-1:0] : cmp_reg;

    // One-shot self-stop loses to a coincident CTRL write.
    en_next     = en_reg;
    per_next    = per_reg;
    irq_en_next = irq_en_reg;
    if (wr_ctrl) begin
      en_next     = bus.bus_wdata[0];
      per_next    = bus.bus_wdata[1];
      irq_en_next = bus.bus_wdata[2];
    end else if (hit && !per_reg) begin
      en_next = 1'b0;
    end

    // A new match beats a coincident write-1-to-clear.
    match_next = match_reg;
    if (hit)
      match_next = 1'b1;
    else if (wr_stat && bus.bus_wdata[0])
      match_next = 1'b0;

    rdata_next = (bus.bus_req && !bus.bus_we) ? rd_val : 32'd0;
  end

  always_ff @(posedge clk_54) begin
    if (srst54) begin
      cnt_reg    <= '0;
      cmp_reg    <= '1;
      en_reg     <= 1'b0;
      per_reg    <= 1'b0;
      irq_en_reg <= 1'b0;
      match_reg  <= 1'b0;
      rdata_reg  <= 32'd0;
      ack_reg    <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      cmp_reg    <= cmp_next;
      en_reg     <= en_next;
      per_reg    <= per_next;
      irq_en_reg <= irq_en_next;
      match_reg  <= match_next;
      rdata_reg  <= rdata_next;
      ack_reg    <= bus.bus_req;
    end
  end

  assign bus.bus_rdata = rdata_reg;
  assign bus.bus_ack   = ack_reg;
  assign irq           = match_reg && irq_en_reg;

endmodule

// File: tb/tb_soc_us_timer.sv
// Self-checking bench for soc_us_timer: a per-cycle reference model of the
// register file drives a negedge compare of irq/bus_ack/bus_rdata, and
// directed scenarios pin the model with hand-computed register reads.
module tb_soc_us_timer;
  logic clk_54 = 1'b0;
  logic srst54;
  logic tick_1us;
  logic irq;

  soc_us_timer_if bus ();

  soc_us_timer #(.CNT_W(32)) dut (
    .clk_54   (clk_54),
    .srst54   (srst54),
    .tick_1us (tick_1us),
    .bus      (bus.slave),
    .irq      (irq)
  );

  always #9 clk_54 = ~clk_54;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_cnt, m_cmp;
  logic        m_en, m_per, m_ie, m_match;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        model_valid = 1'b0;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_cnt;
      2'd1:    return m_cmp;
      2'd2:    return {29'd0, m_ie, m_per, m_en};
      default: return {31'd0, m_match};
    endcase
  endfunction

  always @(posedge clk_54) begin
    if (srst54) begin
      m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
      m_en = 0; m_per = 0; m_ie = 0; m_match = 0;
      m_ack = 0; m_rdata = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      logic        counted, matched;
      logic [31:0] wd;
      wd      = bus.bus_wdata;
      m_ack   = bus.bus_req;
      m_rdata = (bus.bus_req && !bus.bus_we) ? m_read(bus.bus_addr) : 32'd0;
      counted = m_en && tick_1us;
      matched = counted && (m_cnt == m_cmp);
      // tick effects first, then CPU writes take precedence
      if (counted) m_cnt = (matched && m_per) ? 32'd0 : m_cnt + 32'd1;
      if (matched && !m_per) m_en = 0;
      if (matched) m_match = 1;
      if (bus.bus_req && bus.bus_we) begin
        case (bus.bus_addr)
          2'd0: m_cnt = wd;
          2'd1: m_cmp = wd;
          2'd2: begin m_en = wd[0]; m_per = wd[1]; m_ie = wd[2]; end
          default: if (wd[0] && !matched) m_match = 0;
        endcase
      end
    end
  end

  always @(negedge clk_54) begin
    if (model_valid) begin
      check("cyc_irq",   {31'd0, irq}, {31'd0, m_match & m_ie});
      check("cyc_ack",   {31'd0, bus.bus_ack}, {31'd0, m_ack});
      check("cyc_rdata", bus.bus_rdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk_54);
    #1;
  endtask

  task automatic bus_write_t(input logic [1:0] a, input logic [31:0] d, input logic tk);
    bus.bus_req = 1; bus.bus_we = 1; bus.bus_addr = a; bus.bus_wdata = d; tick_1us = tk;
    cycle();
    bus.bus_req = 0; bus.bus_we = 0; tick_1us = 0;
    $display("wr addr=%0d data=0x%08h tick=%0d", a, d, tk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_write_t(a, d, 1'b0);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.bus_req = 1; bus.bus_we = 0; bus.bus_addr = a;
    cycle();
    bus.bus_req = 0;
    d = bus.bus_rdata;
    check("rd_ack", {31'd0, bus.bus_ack}, 32'd1);
    $display("rd addr=%0d data=0x%08h", a, d);
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick_1us = 1;
      cycle();
      tick_1us = 0;
      repeat (gap - 1) cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    srst54 = 1; tick_1us = 0;
    bus.bus_req = 0; bus.bus_we = 0; bus.bus_addr = 0; bus.bus_wdata = 0;
    repeat (3) cycle();
    srst54 = 0;
    cycle();

    // 1: reset mid-count, with a request on the reset edge
    read_chk("rst_cmp0", 2'd1, 32'hFFFF_FFFF);
    bus_write(2'd0, 32'h55);
    read_chk("cnt_55", 2'd0, 32'h55);
    bus_write(2'd2, 32'h1);
    ticks(1, 3);
    read_chk("cnt_56", 2'd0, 32'h56);
    srst54 = 1; bus.bus_req = 1; bus.bus_we = 0; bus.bus_addr = 2'd0;
    cycle();
    srst54 = 0; bus.bus_req = 0;
    check("rst_ack", {31'd0, bus.bus_ack}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", bus.bus_rdata, 32'd0);
    read_chk("rst_cmp", 2'd1, 32'hFFFF_FFFF);
    read_chk("rst_cnt", 2'd0, 32'h0);
    read_chk("rst_ctrl", 2'd2, 32'h0);
    read_chk("rst_stat", 2'd3, 32'h0);

    // 2: periodic, CMP=4
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'h7);
    ticks(4, 54);
    read_chk("per_cnt4", 2'd0, 32'd4);
    check("per_irq0", {31'd0, irq}, 32'd0);
    ticks(1, 54);
    check("per_irq1", {31'd0, irq}, 32'd1);
    read_chk("per_cnt0", 2'd0, 32'd0);
    read_chk("per_stat", 2'd3, 32'd1);
    bus_write(2'd3, 32'd1);
    check("per_clr", {31'd0, irq}, 32'd0);
    ticks(4, 54);
    check("per_irq0b", {31'd0, irq}, 32'd0);
    ticks(1, 54);
    check("per_irq1b", {31'd0, irq}, 32'd1);
    bus_write(2'd2, 32'd0);
    bus_write(2'd3, 32'd1);

    // 3: one-shot, CMP=2
    bus_write(2'd0, 32'd0);
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'h5);
    ticks(2, 4);
    check("os_irq0", {31'd0, irq}, 32'd0);
    ticks(1, 4);
    check("os_irq1", {31'd0, irq}, 32'd1);
    read_chk("os_ctrl", 2'd2, 32'h4);
    read_chk("os_cnt3", 2'd0, 32'd3);
    ticks(2, 4);
    read_chk("os_hold", 2'd0, 32'd3);
    bus_write(2'd2, 32'd0);
    bus_write(2'd3, 32'd1);

    // 4: counter wrap
    bus_write(2'd0, 32'hFFFF_FFFE);
    bus_write(2'd1, 32'h10);
    bus_write(2'd2, 32'h1);
    ticks(2, 2);
    read_chk("wrap_cnt", 2'd0, 32'h0);
    read_chk("wrap_stat", 2'd3, 32'h0);
    ticks(16, 2);
    read_chk("wrap_cnt10", 2'd0, 32'h10);
    read_chk("wrap_stat0", 2'd3, 32'h0);
    ticks(3, 2);
    read_chk("wrap_stat1", 2'd3, 32'h1);
    read_chk("wrap_cnt11", 2'd0, 32'h11);
    bus_write(2'd3, 32'd1);

    // 5: collisions
    bus_write(2'd0, 32'd0);
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'h3);
    ticks(1, 2);
    read_chk("col_stat_a", 2'd3, 32'd1);
    bus_write_t(2'd3, 32'd1, 1'b1);
    read_chk("col_w1c_set", 2'd3, 32'd1);
    bus_write(2'd3, 32'd1);
    read_chk("col_w1c", 2'd3, 32'd0);
    bus_write(2'd1, 32'hFFFF);
    bus_write_t(2'd0, 32'h100, 1'b1);
    read_chk("col_cnt", 2'd0, 32'h100);
    bus_write(2'd2, 32'd0);

    // 6: back-to-back bus traffic
    bus.bus_req = 1; bus.bus_we = 0; bus.bus_addr = 2'd0;
    cycle();
    check("b2b_ack0", {31'd0, bus.bus_ack}, 32'd1);
    check("b2b_cnt", bus.bus_rdata, 32'h100);
    bus.bus_addr = 2'd2;
    cycle();
    check("b2b_ack1", {31'd0, bus.bus_ack}, 32'd1);
    check("b2b_ctrl", bus.bus_rdata, 32'h0);
    bus.bus_we = 1; bus.bus_addr = 2'd1; bus.bus_wdata = 32'd7;
    cycle();
    check("b2b_ack2", {31'd0, bus.bus_ack}, 32'd1);
    check("b2b_wr_rd0", bus.bus_rdata, 32'h0);
    bus.bus_we = 0; bus.bus_addr = 2'd1;
    cycle();
    bus.bus_req = 0;
    check("b2b_ack3", {31'd0, bus.bus_ack}, 32'd1);
    check("b2b_cmp", bus.bus_rdata, 32'd7);
    $display("b2b rd CNT, rd CTRL, wr CMP=7, rd CMP done");
    cycle();
    check("b2b_idle", {31'd0, bus.bus_ack}, 32'd0);
    bus_write(2'd2, 32'hFFFF_FFF8);
    read_chk("ctrl_mask", 2'd2, 32'h0);

    repeat (2) cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
